// File: rtl/cpu_bus_lockstep_checker.sv
// rtl/cpu_bus_lockstep_checker.sv - lockstep compare of reference vs DUV 6502 bus traces
// Purpose: ref transactions are queued in an in-order trace FIFO and popped and compared
//          against DUV transactions, so the two cores may drift by a bounded cycle skew.
//          Detects mismatch, overflow, underflow and timeout; captures the first error.
// Ports:   clk, rst_n (sync, active low), enable (IDLE->RUN)
//          ref_valid/ref_rw/ref_addr/ref_data - reference core bus transaction
//          duv_valid/duv_rw/duv_addr/duv_data - DUV core bus transaction
//          match_cnt, mismatch_cnt, level, err_sticky, err_code,
//          first_err_addr, first_err_exp, first_err_act, busy - status outputs
module cpu_bus_lockstep_checker #(
    parameter int DEPTH       = 16,
    parameter int TIMEOUT     = 64,
    parameter int STOP_ON_ERR = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     ref_valid,
    input  logic                     ref_rw,
    input  logic [15:0]              ref_addr,
    input  logic [7:0]               ref_data,
    input  logic                     duv_valid,
    input  logic                     duv_rw,
    input  logic [15:0]              duv_addr,
    input  logic [7:0]               duv_data,
    output logic [31:0]              match_cnt,
    output logic [31:0]              mismatch_cnt,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err_sticky,
    output logic [2:0]               err_code,
    output logic [15:0]              first_err_addr,
    output logic [7:0]               first_err_exp,
    output logic [7:0]               first_err_act,
    output logic                     busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] E_NONE = 3'd0;
    localparam logic [2:0] E_MIS  = 3'd1;
    localparam logic [2:0] E_OVF  = 3'd2;
    localparam logic [2:0] E_UDF  = 3'd3;
    localparam logic [2:0] E_TMO  = 3'd4;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FAIL} state_t;

    state_t          state_q, state_d;
    logic [24:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [31:0]     match_q, match_d, mis_q, mis_d;
    logic            sticky_q, sticky_d;
    logic [2:0]      code_q, code_d;
    logic [15:0]     faddr_q, faddr_d;
    logic [7:0]      fexp_q, fexp_d, fact_q, fact_d;

    logic            push, pop, cmp_en;
    logic            e_mis, e_ovf, e_udf, e_tmo;
    logic [2:0]      err_now;
    logic            fifo_empty, fifo_full;
    logic [24:0]     ref_entry, duv_entry, exp_entry;

    assign ref_entry  = {ref_rw, ref_addr, ref_data};
    assign duv_entry  = {duv_rw, duv_addr, duv_data};
    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == (AW+1)'(DEPTH));

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        tmo_d    = tmo_q;
        match_d  = match_q;
        mis_d    = mis_q;
        sticky_d = sticky_q;
        code_d   = code_q;
        faddr_d  = faddr_q;
        fexp_d   = fexp_q;
        fact_d   = fact_q;
        push     = 1'b0;
        pop      = 1'b0;
        cmp_en   = 1'b0;
        e_mis    = 1'b0;
        e_ovf    = 1'b0;
        e_udf    = 1'b0;
        e_tmo    = 1'b0;
        err_now  = E_NONE;
        exp_entry = mem_q[rd_ptr_q];

        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                // Both cores on the same cycle with nothing queued: compare directly.
                if (ref_valid && duv_valid && fifo_empty) begin
                    cmp_en    = 1'b1;
                    exp_entry = ref_entry;
                end else begin
                    if (duv_valid) begin
                        if (fifo_empty) e_udf = 1'b1;
                        else begin
                            pop    = 1'b1;
                            cmp_en = 1'b1;
                        end
                    end
                    // A full FIFO still accepts a push when the same cycle pops.
                    if (ref_valid) begin
                        if (fifo_full && !duv_valid) e_ovf = 1'b1;
                        else push = 1'b1;
                    end
                end

                if (cmp_en) begin
                    if (exp_entry == duv_entry) begin
                        if (match_q != '1) match_d = match_q + 32'd1;
                    end else begin
                        if (mis_q != '1) mis_d = mis_q + 32'd1;
                        e_mis = 1'b1;
                    end
                end

                if (duv_valid || fifo_empty) tmo_d = '0;
                else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    e_tmo = 1'b1;
                    tmo_d = '0;
                end else tmo_d = tmo_q + 1'b1;

                if (push) wr_ptr_d = wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
                case ({push, pop})
                    2'b10:   level_d = level_q + 1'b1;
                    2'b01:   level_d = level_q - 1'b1;
                    default: level_d = level_q;
                endcase

                if      (e_mis) err_now = E_MIS;
                else if (e_ovf) err_now = E_OVF;
                else if (e_udf) err_now = E_UDF;
                else if (e_tmo) err_now = E_TMO;

                if (err_now != E_NONE) begin
                    sticky_d = 1'b1;
                    if (code_q == E_NONE) begin
                        code_d = err_now;
                        if (err_now == E_MIS) begin
                            faddr_d = exp_entry[23:8];
                            fexp_d  = exp_entry[7:0];
                            fact_d  = duv_data;
                        end
                    end
                    if (STOP_ON_ERR != 0) state_d = ST_FAIL;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            tmo_q    <= '0;
            match_q  <= '0;
            mis_q    <= '0;
            sticky_q <= 1'b0;
            code_q   <= E_NONE;
            faddr_q  <= '0;
            fexp_q   <= '0;
            fact_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            tmo_q    <= tmo_d;
            match_q  <= match_d;
            mis_q    <= mis_d;
            sticky_q <= sticky_d;
            code_q   <= code_d;
            faddr_q  <= faddr_d;
            fexp_q   <= fexp_d;
            fact_q   <= fact_d;
            if (push) mem_q[wr_ptr_q] <= ref_entry;
        end
    end

    assign match_cnt      = match_q;
    assign mismatch_cnt   = mis_q;
    assign level          = level_q;
    assign err_sticky     = sticky_q;
    assign err_code       = code_q;
    assign first_err_addr = faddr_q;
    assign first_err_exp  = fexp_q;
    assign first_err_act  = fact_q;
    assign busy           = (state_q == ST_RUN);
endmodule

// File: tb/tb_cpu_bus_lockstep_checker.sv
// tb/tb_cpu_bus_lockstep_checker.sv - scoreboard bench for cpu_bus_lockstep_checker
module tb_cpu_bus_lockstep_checker;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, enable;
    logic        ref_valid, ref_rw, duv_valid, duv_rw;
    logic [15:0] ref_addr, duv_addr;
    logic [7:0]  ref_data, duv_data;

    logic [31:0] a_match, a_mis, b_match, b_mis;
    logic [4:0]  a_level, b_level;
    logic        a_sticky, b_sticky, a_busy, b_busy;
    logic [2:0]  a_code, b_code;
    logic [15:0] a_faddr, b_faddr;
    logic [7:0]  a_fexp, b_fexp, a_fact, b_fact;

    cpu_bus_lockstep_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .STOP_ON_ERR(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .ref_valid(ref_valid), .ref_rw(ref_rw), .ref_addr(ref_addr), .ref_data(ref_data),
        .duv_valid(duv_valid), .duv_rw(duv_rw), .duv_addr(duv_addr), .duv_data(duv_data),
        .match_cnt(a_match), .mismatch_cnt(a_mis), .level(a_level), .err_sticky(a_sticky),
        .err_code(a_code), .first_err_addr(a_faddr), .first_err_exp(a_fexp),
        .first_err_act(a_fact), .busy(a_busy)
    );

    cpu_bus_lockstep_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .STOP_ON_ERR(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .ref_valid(ref_valid), .ref_rw(ref_rw), .ref_addr(ref_addr), .ref_data(ref_data),
        .duv_valid(duv_valid), .duv_rw(duv_rw), .duv_addr(duv_addr), .duv_data(duv_data),
        .match_cnt(b_match), .mismatch_cnt(b_mis), .level(b_level), .err_sticky(b_sticky),
        .err_code(b_code), .first_err_addr(b_faddr), .first_err_exp(b_fexp),
        .first_err_act(b_fact), .busy(b_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: ref entries queued as the expected DUV traffic, plus expected status.
    logic [24:0] sb_q [$];
    int unsigned m_match, m_mis;
    bit          m_run, m_fail, m_stop, m_sticky, m_err_cyc, use_b;
    logic [2:0]  m_code;
    logic [15:0] m_addr;
    logic [7:0]  m_exp, m_act;

    task automatic model_reset();
        sb_q.delete();
        m_match = 0; m_mis = 0; m_run = 0; m_fail = 0; m_sticky = 0;
        m_code = 0; m_addr = 0; m_exp = 0; m_act = 0;
    endtask

    task automatic note_err(input logic [2:0] code, input logic [15:0] addr,
                            input logic [7:0] e, input logic [7:0] a);
        m_sticky  = 1;
        m_err_cyc = 1;
        if (m_code == 0) begin
            m_code = code; m_addr = addr; m_exp = e; m_act = a;
        end
    endtask

    task automatic model_cmp(input logic [24:0] e, input logic [24:0] a);
        if (e == a) m_match++;
        else begin
            m_mis++;
            note_err(3'd1, e[23:8], e[7:0], a[7:0]);
        end
    endtask

    task automatic drive(input bit rv, input logic [24:0] r, input bit dv, input logic [24:0] d);
        ref_valid = rv; {ref_rw, ref_addr, ref_data} = r;
        duv_valid = dv; {duv_rw, duv_addr, duv_data} = d;
        @(posedge clk);
        #1;
        ref_valid = 0; duv_valid = 0;
        m_err_cyc = 0;
        if (m_run && !m_fail) begin
            if (rv && dv && sb_q.size() == 0) model_cmp(r, d);
            else begin
                if (dv) begin
                    if (sb_q.size() == 0) note_err(3'd3, 16'h0, 8'h0, 8'h0);
                    else model_cmp(sb_q.pop_front(), d);
                end
                if (rv) begin
                    if (sb_q.size() == DEPTH && !dv) note_err(3'd2, 16'h0, 8'h0, 8'h0);
                    else sb_q.push_back(r);
                end
            end
            if (m_err_cyc && m_stop) m_fail = 1;
        end
    endtask

    task automatic do_reset();
        rst_n = 0; enable = 0; ref_valid = 0; duv_valid = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
    endtask

    // Enable cycle also carries a ref transaction, which must be ignored in IDLE.
    task automatic start();
        enable = 1;
        ref_valid = 1; {ref_rw, ref_addr, ref_data} = {1'b1, 16'h1234, 8'h56};
        @(posedge clk);
        #1;
        enable = 0; ref_valid = 0;
        m_run = 1;
    endtask

    task automatic check_model(input string pfx);
        check({pfx, ".match"},  use_b ? b_match  : a_match,  m_match);
        check({pfx, ".mis"},    use_b ? b_mis    : a_mis,    m_mis);
        check({pfx, ".level"},  32'(use_b ? b_level : a_level), sb_q.size());
        check({pfx, ".code"},   32'(use_b ? b_code : a_code), 32'(m_code));
        check({pfx, ".sticky"}, 32'(use_b ? b_sticky : a_sticky), 32'(m_sticky));
        check({pfx, ".busy"},   32'(use_b ? b_busy : a_busy), 32'(m_run && !m_fail));
        check({pfx, ".faddr"},  32'(use_b ? b_faddr : a_faddr), 32'(m_addr));
        check({pfx, ".fexp"},   32'(use_b ? b_fexp : a_fexp), 32'(m_exp));
        check({pfx, ".fact"},   32'(use_b ? b_fact : a_fact), 32'(m_act));
    endtask

    initial begin
        use_b = 0; m_stop = 1;
        rst_n = 0; enable = 0; ref_valid = 0; duv_valid = 0;
        ref_rw = 0; duv_rw = 0; ref_addr = 0; duv_addr = 0; ref_data = 0; duv_data = 0;

        do_reset();
        check_model("reset");
        start();
        check_model("enable");

        // 1: matched read two cycles apart, then overlapping push+pop
        drive(1, {1'b1, 16'hFFFC, 8'h00}, 0, '0);
        check_model("t1.push");
        drive(0, '0, 0, '0);
        drive(0, '0, 1, {1'b1, 16'hFFFC, 8'h00});
        check_model("t1.pop");
        drive(1, {1'b0, 16'h0010, 8'h11}, 0, '0);
        drive(1, {1'b1, 16'h0011, 8'h22}, 1, {1'b0, 16'h0010, 8'h11});
        check_model("t1.pushpop");
        drive(0, '0, 1, {1'b1, 16'h0011, 8'h22});
        check_model("t1.drain");

        // 2: write data mismatch stops the checker
        do_reset(); start();
        drive(1, {1'b0, 16'h0200, 8'hA9}, 0, '0);
        drive(0, '0, 1, {1'b0, 16'h0200, 8'hA8});
        check_model("t2.mis");
        drive(1, {1'b0, 16'h0300, 8'h01}, 1, {1'b0, 16'h0300, 8'h01});
        check_model("t2.frozen");

        // 3: overflow on the (DEPTH+1)th ref transaction
        do_reset(); start();
        for (int i = 0; i <= DEPTH; i++) begin
            drive(1, {1'b1, 16'(16'h4000 + i), 8'(i)}, 0, '0);
            check_model($sformatf("t3.%0d", i));
        end

        // 4: underflow
        do_reset(); start();
        drive(0, '0, 1, {1'b1, 16'h0000, 8'h00});
        check_model("t4.udf");

        // 5: timeout after TIMEOUT silent cycles
        do_reset(); start();
        drive(1, {1'b1, 16'h8000, 8'h4C}, 0, '0);
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        check("t5.code_early", 32'(a_code), 32'd0);
        check("t5.busy_early", 32'(a_busy), 32'd1);
        @(posedge clk);
        #1;
        check("t5.code", 32'(a_code), 32'd4);
        check("t5.sticky", 32'(a_sticky), 32'd1);
        check("t5.busy", 32'(a_busy), 32'd0);
        check("t5.faddr", 32'(a_faddr), 32'd0);
        check("t5.level", 32'(a_level), 32'd1);

        // 6: continue-on-error instance, 100 lockstep txns with 3 corrupted, then reset
        use_b = 1; m_stop = 0;
        do_reset(); start();
        for (int i = 0; i < 100; i++) begin
            logic [15:0] ad;
            logic [7:0]  dt, dd;
            ad = 16'(i * 37);
            dt = 8'(i);
            dd = (i == 17 || i == 50 || i == 83) ? (dt ^ 8'h01) : dt;
            drive(1, {i[0], ad, dt}, 1, {i[0], ad, dd});
        end
        check_model("t6.stream");
        for (int i = 0; i < 3; i++) drive(1, {1'b1, 16'(16'h7000 + i), 8'hEE}, 0, '0);
        check_model("t6.queued");
        rst_n = 0; ref_valid = 1; duv_valid = 1;
        @(posedge clk);
        #1;
        rst_n = 1; ref_valid = 0; duv_valid = 0;
        model_reset();
        check_model("t6.reset");
        start();
        drive(0, '0, 1, {1'b1, 16'h7000, 8'hEE});
        check_model("t6.after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
